// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the two-client SDRAM burst scheduler.
//   - sched_state_t : scheduler FSM states
//   - ADDR_W        : SDRAM word address width
//   - WR_BURST_W    : width of the write burst-length output
//   - RD_BURST_W    : width of the read burst-length output
package sdram_sched_pkg;

    localparam int ADDR_W     = 21;
    localparam int WR_BURST_W = 9;
    localparam int RD_BURST_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RUN,
        ST_RD_REQ,
        ST_RD_RUN
    } sched_state_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-client burst offset tracker.
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_start  : one-cycle frame-begin pulse from the client
//   busy         : client is in (or entering) its REQ/RUN phase
//   finish       : accepted burst-finish pulse (only while in RUN)
//   off          : current word offset within the frame
//   start_apply  : pulse when a frame start takes effect on the offset
// WRAP=1 returns the offset to 0 at the end of the frame (read side);
// WRAP=0 parks it at FRAME_WORDS until the next frame start (write side).
module sdram_addr_gen
    import sdram_sched_pkg::*;
#(
    parameter bit          WRAP        = 1'b0,
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned FRAME_WORDS = 307200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              busy,
    input  logic              finish,
    output logic [ADDR_W-1:0] off,
    output logic              start_apply
);

    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);

    logic [ADDR_W-1:0] off_q, off_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] adv;

    always_comb begin
        adv         = off_q + BURST_A;
        off_d       = off_q;
        pend_d      = pend_q;
        start_apply = 1'b0;
        if (finish) begin
            // A start seen during the burst (latched or arriving with the
            // finish) replaces the normal advance.
            if (pend_q || frame_start) begin
                off_d       = '0;
                pend_d      = 1'b0;
                start_apply = 1'b1;
            end else if (adv >= FRAME_A) begin
                off_d = WRAP ? '0 : FRAME_A;
            end else begin
                off_d = adv;
            end
        end else if (frame_start) begin
            if (busy) begin
                pend_d = 1'b1;
            end else begin
                off_d       = '0;
                start_apply = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            off_q  <= off_d;
            pend_q <= pend_d;
        end
    end

    assign off = off_q;

endmodule

// File: rtl/sdram_port_sched.sv
// Two-client burst scheduler in front of sdram_controller. Arbitrates the
// single SDRAM port between the camera write FIFO and the display read FIFO
// and generates burst start addresses.
// Ports: clk/rst_n; sdram_init_done; wr/rd_frame_start pulses; wr/rd FIFO
// levels; write and read request/ack/addr/burst/finish handshakes to the
// controller; wr_buf_sel/rd_buf_sel frame-store buffer selects.
// Build option: SDRAM_PINGPONG_EN enables double buffering of the frame
// store; without it both buffer selects are tied to 0.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | evaluate eligibility, pick next client
// ST_WR_REQ | sdram_wr_req high, waiting for sdram_wr_ack
// ST_WR_RUN | write burst in progress, waiting for finish
// ST_RD_REQ | sdram_rd_req high, waiting for sdram_rd_ack
// ST_RD_RUN | read burst in progress, waiting for finish
module sdram_port_sched
    import sdram_sched_pkg::*;
#(
    parameter int unsigned       BURST_LEN     = 256,
    parameter int unsigned       FRAME_WORDS   = 307200,
    parameter logic [ADDR_W-1:0] BUF0_BASE     = 21'h000000,
    parameter logic [ADDR_W-1:0] BUF1_BASE     = 21'h080000,
    parameter int unsigned       RD_FIFO_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sdram_init_done,
    input  logic                  wr_frame_start,
    input  logic                  rd_frame_start,
    input  logic [9:0]            wr_fifo_level,
    input  logic [9:0]            rd_fifo_level,
    output logic                  sdram_wr_req,
    input  logic                  sdram_wr_ack,
    output logic [ADDR_W-1:0]     sdram_wr_addr,
    output logic [WR_BURST_W-1:0] sdram_wr_burst,
    input  logic                  wr_burst_finish,
    output logic                  sdram_rd_req,
    input  logic                  sdram_rd_ack,
    output logic [ADDR_W-1:0]     sdram_rd_addr,
    output logic [RD_BURST_W-1:0] sdram_rd_burst,
    input  logic                  rd_burst_finish,
    output logic                  wr_buf_sel,
    output logic                  rd_buf_sel
);

    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);

    sched_state_t          state_q, state_d;
    logic                  last_was_wr_q, last_was_wr_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [WR_BURST_W-1:0] wr_burst_q, wr_burst_d;
    logic [RD_BURST_W-1:0] rd_burst_q, rd_burst_d;

    logic [ADDR_W-1:0] wr_off, rd_off;
    logic              wr_elig, rd_elig;
    logic              wr_busy, rd_busy;
    logic              wr_fin, rd_fin;
    logic              wr_start_apply, rd_start_apply;
    logic              wr_sel, rd_sel;

    assign wr_elig = sdram_init_done && (32'(wr_fifo_level) >= BURST_LEN)
                     && (wr_off < FRAME_A);
    assign rd_elig = sdram_init_done
                     && ((32'(rd_fifo_level) + BURST_LEN) <= RD_FIFO_DEPTH);

    always_comb begin
        state_d       = state_q;
        last_was_wr_d = last_was_wr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_elig && (!rd_elig || !last_was_wr_q)) begin
                    state_d       = ST_WR_REQ;
                    last_was_wr_d = 1'b1;
                end else if (rd_elig) begin
                    state_d       = ST_RD_REQ;
                    last_was_wr_d = 1'b0;
                end
            end
            ST_WR_REQ: if (sdram_wr_ack)    state_d = ST_WR_RUN;
            ST_WR_RUN: if (wr_burst_finish) state_d = ST_IDLE;
            ST_RD_REQ: if (sdram_rd_ack)    state_d = ST_RD_RUN;
            ST_RD_RUN: if (rd_burst_finish) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // A frame start arriving in the same cycle IDLE commits to a request is
    // treated as mid-burst: the address already captured stays consistent
    // with the offset that burst will advance.
    assign wr_busy = (state_q == ST_WR_REQ) || (state_q == ST_WR_RUN)
                     || (state_d == ST_WR_REQ);
    assign rd_busy = (state_q == ST_RD_REQ) || (state_q == ST_RD_RUN)
                     || (state_d == ST_RD_REQ);
    assign wr_fin  = (state_q == ST_WR_RUN) && wr_burst_finish;
    assign rd_fin  = (state_q == ST_RD_RUN) && rd_burst_finish;

    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_burst_d = wr_burst_q;
        rd_burst_d = rd_burst_q;
        if ((state_q == ST_IDLE) && (state_d == ST_WR_REQ)) begin
            wr_addr_d  = (wr_sel ? BUF1_BASE : BUF0_BASE) + wr_off;
            wr_burst_d = WR_BURST_W'(BURST_LEN);
        end
        if ((state_q == ST_IDLE) && (state_d == ST_RD_REQ)) begin
            rd_addr_d  = (rd_sel ? BUF1_BASE : BUF0_BASE) + rd_off;
            rd_burst_d = RD_BURST_W'(BURST_LEN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_was_wr_q <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            wr_burst_q    <= '0;
            rd_burst_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_was_wr_q <= last_was_wr_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            wr_burst_q    <= wr_burst_d;
            rd_burst_q    <= rd_burst_d;
        end
    end

    sdram_addr_gen #(
        .WRAP        (1'b0),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_wr_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (wr_frame_start),
        .busy        (wr_busy),
        .finish      (wr_fin),
        .off         (wr_off),
        .start_apply (wr_start_apply)
    );

    sdram_addr_gen #(
        .WRAP        (1'b1),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_rd_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (rd_frame_start),
        .busy        (rd_busy),
        .finish      (rd_fin),
        .off         (rd_off),
        .start_apply (rd_start_apply)
    );

`ifdef SDRAM_PINGPONG_EN
    logic wr_sel_q, wr_sel_d;
    logic rd_sel_q, rd_sel_d;
    logic last_done_q, last_done_d;
    logic done_flag_q, done_flag_d;
    logic wr_frame_end;

    // The buffer only flips on a start that follows a completed frame, so a
    // start pulse before the first frame finishes keeps writing buffer 0.
    always_comb begin
        wr_frame_end = wr_fin && ((wr_off + BURST_A) >= FRAME_A);
        last_done_d  = wr_frame_end ? wr_sel_q : last_done_q;
        done_flag_d  = done_flag_q;
        wr_sel_d     = wr_sel_q;
        if (wr_frame_end) begin
            done_flag_d = 1'b1;
        end
        if (wr_start_apply) begin
            done_flag_d = 1'b0;
            if (done_flag_q || wr_frame_end) begin
                wr_sel_d = ~wr_sel_q;
            end
        end
        rd_sel_d = rd_start_apply ? last_done_d : rd_sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            last_done_q <= 1'b0;
            done_flag_q <= 1'b0;
        end else begin
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            last_done_q <= last_done_d;
            done_flag_q <= done_flag_d;
        end
    end

    assign wr_sel = wr_sel_q;
    assign rd_sel = rd_sel_q;
`else
    logic unused_start;
    assign unused_start = wr_start_apply ^ rd_start_apply;
    assign wr_sel       = 1'b0;
    assign rd_sel       = 1'b0;
`endif

    assign sdram_wr_req   = (state_q == ST_WR_REQ);
    assign sdram_rd_req   = (state_q == ST_RD_REQ);
    assign sdram_wr_addr  = wr_addr_q;
    assign sdram_rd_addr  = rd_addr_q;
    assign sdram_wr_burst = wr_burst_q;
    assign sdram_rd_burst = rd_burst_q;
    assign wr_buf_sel     = wr_sel;
    assign rd_buf_sel     = rd_sel;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched: init gating, tie arbitration, read
// wrap, write saturation/restart, frame-start latching, buffer selection
// and asynchronous reset mid-burst. Expected buffer selects follow the
// SDRAM_PINGPONG_EN build option.
module tb_sdram_port_sched;

`ifdef SDRAM_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif
    localparam int BASE1 = PP ? 32'h080000 : 32'h000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic        wr_frame_start;
    logic        rd_frame_start;
    logic [9:0]  wr_fifo_level;
    logic [9:0]  rd_fifo_level;
    logic        sdram_wr_req;
    logic        sdram_wr_ack;
    logic [20:0] sdram_wr_addr;
    logic [8:0]  sdram_wr_burst;
    logic        wr_burst_finish;
    logic        sdram_rd_req;
    logic        sdram_rd_ack;
    logic [20:0] sdram_rd_addr;
    logic [9:0]  sdram_rd_burst;
    logic        rd_burst_finish;
    logic        wr_buf_sel;
    logic        rd_buf_sel;

    int vec_cnt = 0;
    int err_cnt = 0;

    sdram_port_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wr_frame_start  (wr_frame_start),
        .rd_frame_start  (rd_frame_start),
        .wr_fifo_level   (wr_fifo_level),
        .rd_fifo_level   (rd_fifo_level),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_burst  (sdram_wr_burst),
        .wr_burst_finish (wr_burst_finish),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_rd_burst  (sdram_rd_burst),
        .rd_burst_finish (rd_burst_finish),
        .wr_buf_sel      (wr_buf_sel),
        .rd_buf_sel      (rd_buf_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        sdram_init_done = 1'b0;
        wr_frame_start  = 1'b0;
        rd_frame_start  = 1'b0;
        wr_fifo_level   = '0;
        rd_fifo_level   = '0;
        sdram_wr_ack    = 1'b0;
        sdram_rd_ack    = 1'b0;
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_wr_req(output bit ok);
        int n = 0;
        while (!sdram_wr_req && n < 20) begin
            tick();
            n++;
        end
        ok = sdram_wr_req;
        if (!ok) chk("wr_req_timeout", 32'(sdram_wr_req), 32'd1);
    endtask

    task automatic wait_rd_req(output bit ok);
        int n = 0;
        while (!sdram_rd_req && n < 20) begin
            tick();
            n++;
        end
        ok = sdram_rd_req;
        if (!ok) chk("rd_req_timeout", 32'(sdram_rd_req), 32'd1);
    endtask

    // One complete write burst; optionally pulses wr_frame_start during RUN.
    task automatic wr_burst(input int exp_addr, input bit start_in_run);
        bit ok;
        wait_wr_req(ok);
        if (ok) begin
            chk("wr_addr", 32'(sdram_wr_addr), 32'(exp_addr));
            sdram_wr_ack = 1'b1;
            tick();
            sdram_wr_ack = 1'b0;
            chk("wr_req_drop", 32'(sdram_wr_req), 32'd0);
            if (start_in_run) begin
                wr_frame_start = 1'b1;
                tick();
                wr_frame_start = 1'b0;
            end
            chk("wr_addr_hold", 32'(sdram_wr_addr), 32'(exp_addr));
            wr_burst_finish = 1'b1;
            tick();
            wr_burst_finish = 1'b0;
        end
    endtask

    task automatic rd_burst(input int exp_addr);
        bit ok;
        wait_rd_req(ok);
        if (ok) begin
            chk("rd_addr", 32'(sdram_rd_addr), 32'(exp_addr));
            sdram_rd_ack = 1'b1;
            tick();
            sdram_rd_ack = 1'b0;
            chk("rd_req_drop", 32'(sdram_rd_req), 32'd0);
            rd_burst_finish = 1'b1;
            tick();
            rd_burst_finish = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        bit seen;

        // Reset state
        do_reset();
        chk("rst_wr_req",   32'(sdram_wr_req),   32'd0);
        chk("rst_rd_req",   32'(sdram_rd_req),   32'd0);
        chk("rst_wr_addr",  32'(sdram_wr_addr),  32'd0);
        chk("rst_rd_addr",  32'(sdram_rd_addr),  32'd0);
        chk("rst_wr_burst", 32'(sdram_wr_burst), 32'd0);
        chk("rst_rd_burst", 32'(sdram_rd_burst), 32'd0);
        chk("rst_wr_sel",   32'(wr_buf_sel),     32'd0);
        chk("rst_rd_sel",   32'(rd_buf_sel),     32'd0);

        // Init gating; a stray finish in IDLE must not move the offset.
        wr_fifo_level = 10'd300;
        rd_fifo_level = 10'd1000;
        wr_burst_finish = 1'b1;
        tick();
        wr_burst_finish = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= sdram_wr_req | sdram_rd_req;
        end
        chk("init_gate", 32'(seen), 32'd0);
        sdram_init_done = 1'b1;
        tick();
        tick();
        chk("init_wr_req", 32'(sdram_wr_req), 32'd1);
        chk("init_wr_burst", 32'(sdram_wr_burst), 32'd256);
        wr_burst(0, 1'b0);

        // Tie: write wins after reset, then read, then write again.
        do_reset();
        sdram_init_done = 1'b1;
        wr_fifo_level   = 10'd300;
        rd_fifo_level   = 10'd0;
        wait_wr_req(ok);
        chk("tie1_rd_req", 32'(sdram_rd_req), 32'd0);
        wr_burst(0, 1'b0);
        chk("turnaround_idle", 32'(sdram_wr_req | sdram_rd_req), 32'd0);
        wait_rd_req(ok);
        chk("tie2_wr_req", 32'(sdram_wr_req), 32'd0);
        chk("tie2_rd_burst", 32'(sdram_rd_burst), 32'd256);
        rd_burst(0);
        wait_wr_req(ok);
        chk("tie3_rd_req", 32'(sdram_rd_req), 32'd0);
        wr_burst(256, 1'b0);

        // Read wrap across 1200 bursts
        do_reset();
        sdram_init_done = 1'b1;
        rd_fifo_level   = 10'd768;
        for (int i = 0; i <= 1200; i++) begin
            rd_burst((i * 256) % 307200);
        end

        // Write saturation over frame 0
        do_reset();
        sdram_init_done = 1'b1;
        wr_fifo_level   = 10'd512;
        rd_fifo_level   = 10'd1000;
        for (int i = 0; i < 1200; i++) begin
            wr_burst(i * 256, 1'b0);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= sdram_wr_req;
        end
        chk("wr_saturate_stop", 32'(seen), 32'd0);

        // Restart in idle: buffer flips when double-buffered
        wr_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
        wr_burst(BASE1, 1'b0);
        chk("wr_sel_frame1", 32'(wr_buf_sel), 32'(PP));

        // Display starts a frame: reads the completed buffer 0
        wr_fifo_level  = 10'd0;
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        chk("rd_sel_frame1", 32'(rd_buf_sel), 32'd0);
        rd_fifo_level = 10'd0;
        rd_burst(0);

        // Rest of frame 1, start latched during the last burst
        rd_fifo_level = 10'd1000;
        wr_fifo_level = 10'd512;
        for (int i = 1; i < 1200; i++) begin
            wr_burst(BASE1 + i * 256, i == 1199);
        end
        wr_burst(0, 1'b0);
        chk("wr_sel_frame2", 32'(wr_buf_sel), 32'd0);
        wr_fifo_level  = 10'd0;
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        chk("rd_sel_frame2", 32'(rd_buf_sel), 32'(PP));

        // Reset during WR_RUN
        do_reset();
        sdram_init_done = 1'b1;
        wr_fifo_level   = 10'd300;
        rd_fifo_level   = 10'd1000;
        wr_burst(0, 1'b0);
        wait_wr_req(ok);
        chk("pre_rst_addr", 32'(sdram_wr_addr), 32'd256);
        sdram_wr_ack = 1'b1;
        tick();
        sdram_wr_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_req",   32'(sdram_wr_req),   32'd0);
        chk("midrst_wr_addr",  32'(sdram_wr_addr),  32'd0);
        chk("midrst_wr_burst", 32'(sdram_wr_burst), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wr_burst(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
